// File: rtl/display_pkg.sv
// Shared definitions for the display scan controller.
// Contents:
//   sel_e      - digit-slot FSM states (ones, tens, hundreds)
//   SEG_*      - active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
package display_pkg;

    typedef enum logic [1:0] {
        Sel0 = 2'd0,  // ones slot
        Sel1 = 2'd1,  // tens slot
        Sel2 = 2'd2   // hundreds slot
    } sel_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder.
// Ports:
//   code_i  in  4  digit code; 0-9 decode normally, 10-15 show a dash
//   seg_o   out 7  active-low segments {g,f,e,d,c,b,a}
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (code_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            // Out-of-range codes are an upstream error; show a dash.
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexes three BCD digits onto a shared 7-segment bus with per-digit
// active-low anode enables. New digits are taken into a shadow copy only at the
// hundreds->ones frame boundary, so a frame never mixes old and new values.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   digit0..2       ones / tens / hundreds BCD input
//   blank_lz        1 = suppress leading zeros (judged on the shadow digits)
//   update_req      request to latch digit0..2, held until update_ack
//   update_ack      one-cycle pulse, high the cycle the new shadow takes effect
//   an[2:0]         anode enables, active-low, an[i] drives digit i
//   seg[6:0]        {g,f,e,d,c,b,a}, active-low
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic       blank_lz,
    input  logic       update_req,
    output logic       update_ack,
    output logic [2:0] an,
    output logic [6:0] seg
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    sel_e            state_q, state_d;
    logic [3:0]      sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic            ack_q, ack_d;
    logic [2:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;

    logic            wrap;
    logic            latch;
    logic [3:0]      cur_digit;
    logic [2:0]      slot_an;
    logic            lz_blank;
    logic [6:0]      dec_seg;

    seg7_decode u_dec (
        .code_i (cur_digit),
        .seg_o  (dec_seg)
    );

    always_comb begin
        wrap    = (cnt_q == CntW'(SCAN_DIV - 1));
        cnt_d   = wrap ? '0 : cnt_q + CntW'(1);
        state_d = state_q;
        if (wrap) begin
            case (state_q)
                Sel0:    state_d = Sel1;
                Sel1:    state_d = Sel2;
                default: state_d = Sel0;
            endcase
        end

        // Shadow only changes on the frame wrap, keeping each frame consistent.
        latch = wrap && (state_q == Sel2) && update_req;
        sh0_d = latch ? digit0 : sh0_q;
        sh1_d = latch ? digit1 : sh1_q;
        sh2_d = latch ? digit2 : sh2_q;
        ack_d = latch;

        case (state_q)
            Sel0: begin
                cur_digit = sh0_q;
                slot_an   = 3'b110;
                lz_blank  = 1'b0;
            end
            Sel1: begin
                cur_digit = sh1_q;
                slot_an   = 3'b101;
                lz_blank  = blank_lz && (sh1_q == 4'd0) && (sh2_q == 4'd0);
            end
            default: begin
                cur_digit = sh2_q;
                slot_an   = 3'b011;
                lz_blank  = blank_lz && (sh2_q == 4'd0);
            end
        endcase

        // Anti-ghosting gap at slot start, or a suppressed leading zero.
        if ((cnt_q < CntW'(BLANK_CYCLES)) || lz_blank) begin
            an_d  = 3'b111;
            seg_d = SEG_BLANK;
        end else begin
            an_d  = slot_an;
            seg_d = dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= Sel0;
            sh0_q   <= 4'd0;
            sh1_q   <= 4'd0;
            sh2_q   <= 4'd0;
            ack_q   <= 1'b0;
            an_q    <= 3'b111;
            seg_q   <= SEG_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            ack_q   <= ack_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign update_ack = ack_q;
    assign an         = an_q;
    assign seg        = seg_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with SCAN_DIV=8, BLANK_CYCLES=2.
module tb_display_scan_ctrl;

    localparam int unsigned D = 8;
    localparam int unsigned B = 2;
    localparam int unsigned F = 3 * D;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d0, d1, d2;
    logic       lz, req;
    logic       ack;
    logic [2:0] an;
    logic [6:0] seg;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .SCAN_DIV     (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digit0     (d0),
        .digit1     (d1),
        .digit2     (d2),
        .blank_lz   (lz),
        .update_req (req),
        .update_ack (ack),
        .an         (an),
        .seg        (seg)
    );

    typedef struct packed {
        logic [2:0] an;
        logic [6:0] seg;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: position within the frame plus the displayed digits.
    int         m_pos;
    logic [3:0] m_sh [3];

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    initial begin
        exp_t e;
        int   slot, c;
        logic blanked;
        m_pos = 0;
        for (int i = 0; i < 3; i++) m_sh[i] = 4'd0;
        forever begin
            @(posedge clk);
            if (rst) begin
                e.an  = 3'b111;
                e.seg = 7'b1111111;
                e.ack = 1'b0;
                m_pos = 0;
                for (int i = 0; i < 3; i++) m_sh[i] = 4'd0;
            end else begin
                slot    = m_pos / D;
                c       = m_pos % D;
                blanked = (slot == 2 && lz && m_sh[2] == 0) ||
                          (slot == 1 && lz && m_sh[1] == 0 && m_sh[2] == 0);
                if (c < B || blanked) begin
                    e.an  = 3'b111;
                    e.seg = 7'b1111111;
                end else begin
                    e.an  = ~(3'(1) << slot);
                    e.seg = ref_seg(m_sh[slot]);
                end
                e.ack = (m_pos == F - 1) && req;
                if (e.ack) begin
                    m_sh[0] = d0;
                    m_sh[1] = d1;
                    m_sh[2] = d2;
                end
                m_pos = (m_pos + 1) % F;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: every cycle the DUT presents a registered output word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (an !== e.an) begin
                    errors++;
                    $display("FAIL an: got %b expected %b at %0t", an, e.an, $time);
                end
                checks++;
                if (seg !== e.seg) begin
                    errors++;
                    $display("FAIL seg: got %b expected %b at %0t", seg, e.seg, $time);
                end
                checks++;
                if (ack !== e.ack) begin
                    errors++;
                    $display("FAIL ack: got %b expected %b at %0t", ack, e.ack, $time);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input int bound);
        int k = 0;
        while (!ack && k < bound) begin
            tick(1);
            k++;
        end
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL ack_timeout: got ack=%b after %0d cycles, required 1", ack, k);
        end
    endtask

    task automatic request(input logic [3:0] a, input logic [3:0] b, input logic [3:0] h);
        d0  = a;
        d1  = b;
        d2  = h;
        req = 1'b1;
        wait_ack(2 * F + 2);
        req = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        int k = 0;
        while (m_pos != p && k < 2 * F) begin
            tick(1);
            k++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req = 1'b0;
        lz  = 1'b0;
        d0  = 4'd0;
        d1  = 4'd0;
        d2  = 4'd0;
        tick(3);
        rst = 1'b0;

        // Digits 3,2,1 without blanking, then one full frame displayed.
        request(4'd3, 4'd2, 4'd1);
        tick(F + 3);

        // Request raised mid-tens slot with new digits; held request acks once per frame.
        wait_pos(D + 3);
        d0  = 4'd7;
        d1  = 4'd8;
        d2  = 4'd9;
        req = 1'b1;
        wait_ack(2 * F + 2);
        n = 0;
        tick(1);
        while (!ack && n < 2 * F) begin
            d0 = 4'($urandom_range(0, 9));
            d1 = 4'($urandom_range(0, 9));
            d2 = 4'($urandom_range(0, 9));
            tick(1);
            n++;
        end
        n++;
        checks++;
        if (n != F) begin
            errors++;
            $display("FAIL ack_interval: got %0d cycles, required %0d", n, F);
        end
        req = 1'b0;
        tick(F);

        // Leading-zero blanking cases, and an out-of-range ones digit.
        lz = 1'b1;
        request(4'd5, 4'd0, 4'd0);
        tick(F + 2);
        request(4'd0, 4'd0, 4'd0);
        tick(F + 2);
        request(4'd0, 4'd0, 4'd1);
        tick(F + 2);
        request(4'd12, 4'd4, 4'd0);
        tick(F + 2);

        // Reset during the tens slot with a request pending.
        wait_pos(D + 4);
        req = 1'b1;
        d0  = 4'd6;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        req = 1'b0;
        tick(F + 4);

        // Randomized mix of requests, abandoned requests, input churn and resets.
        repeat (30) begin
            lz = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: request(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                           4'($urandom_range(0, 15)));
                1: begin
                    d0  = 4'($urandom_range(0, 15));
                    d1  = 4'($urandom_range(0, 15));
                    d2  = 4'($urandom_range(0, 15));
                    req = 1'b1;
                    tick($urandom_range(1, 12));
                    req = 1'b0;
                end
                2: repeat ($urandom_range(1, 20)) begin
                    d0 = 4'($urandom_range(0, 15));
                    d1 = 4'($urandom_range(0, 15));
                    d2 = 4'($urandom_range(0, 15));
                    tick(1);
                end
                default: begin
                    rst = 1'b1;
                    tick($urandom_range(1, 2));
                    rst = 1'b0;
                end
            endcase
            tick($urandom_range(1, 30));
        end

        tick(2);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
